// File: rtl/reg_arb_pkg.sv
// Shared constants and helpers for the register-bus arbiter.
// Holds the FSM encodings and the round-robin winner search.
package reg_arb_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RD_RET  = 2'd3;

    localparam int MAX_MASTERS = 8;
    localparam int LAT_W       = 3;

    // Width of a grant index for n masters, never below one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requesting index at or after ptr, searched cyclically over n.
    function automatic logic [2:0] next_rr(
        input logic [2:0] ptr,
        input logic [7:0] req,
        input int         n
    );
        logic [2:0] win;
        logic [2:0] idx;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = 3'((int'(ptr) + i) % n);
            if (!found && (i < n) && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM register bus between the arbiter and the register slave.
// Fixed-latency reads, no slave-side waitrequest.
interface avalon_mm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin grant search.
// Picks the first requester at or after the rotating pointer.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Winner index is only meaningful while gnt_valid is high.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = GW'(next_rr(3'(ptr), 8'(req), N));
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin sharing of one Avalon-MM register slave among masters.
// One transaction in flight; read data is steered to its issuer.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0] m_address,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS-1:0]             m_write,
    input  logic [N_MASTERS-1:0][DATA_W-1:0] m_writedata,
    output logic [N_MASTERS-1:0]             m_waitrequest,
    output logic [DATA_W-1:0]                m_readdata,
    output logic [N_MASTERS-1:0]             m_readdatavalid,
    avalon_mm_if.master                      reg_mm
);

    localparam int GW = grant_w(N_MASTERS);

    logic [1:0]           state_q,   state_d;
    logic [GW-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [GW-1:0]        grant_q,   grant_d;
    logic                 wr_q,      wr_d;
    logic [ADDR_W-1:0]    addr_q,    addr_d;
    logic [DATA_W-1:0]    wdata_q,   wdata_d;
    logic [LAT_W-1:0]     lat_q,     lat_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    logic [N_MASTERS-1:0] rdv_q,     rdv_d;

    logic [N_MASTERS-1:0] req;
    logic [GW-1:0]        gnt_idx;
    logic                 gnt_valid;

    assign req = m_read | m_write;

    rr_arbiter #(
        .N  (N_MASTERS),
        .GW (GW)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Next-state and datapath: arbitrate in IDLE, then walk the transaction.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        rdata_d  = rdata_q;
        rdv_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx;
                    wr_d    = m_write[gnt_idx];
                    addr_d  = m_address[gnt_idx];
                    wdata_d = m_writedata[gnt_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (grant_q == GW'(N_MASTERS - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_q + GW'(1);
                end
                if (wr_q) begin
                    state_d = S_IDLE;
                end else begin
                    lat_d   = LAT_W'(READ_LATENCY - 1);
                    state_d = (READ_LATENCY > 1) ? S_RD_WAIT : S_RD_RET;
                end
            end
            S_RD_WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    lat_d   = '0;
                    state_d = S_RD_RET;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RD_RET: begin
                rdata_d        = reg_mm.readdata;
                rdv_d[grant_q] = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall every master except the granted one during its ISSUE cycle.
    always_comb begin
        m_waitrequest = '1;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((state_q == S_ISSUE) && (grant_q == GW'(i))) begin
                m_waitrequest[i] = 1'b0;
            end
        end
    end

    assign reg_mm.read      = (state_q == S_ISSUE) && !wr_q;
    assign reg_mm.write     = (state_q == S_ISSUE) && wr_q;
    assign reg_mm.address   = addr_q;
    assign reg_mm.writedata = wdata_q;

    assign m_readdata      = rdata_q;
    assign m_readdatavalid = rdv_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            rdata_q  <= '0;
            rdv_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            rdata_q  <= rdata_d;
            rdv_q    <= rdv_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter with a fixed-latency slave model.
// Two masters, READ_LATENCY=3, slave register 0 is an event counter.
module tb_reg_bus_arbiter;

    localparam int N  = 2;
    localparam int RL = 3;

    typedef struct {
        bit          wr;
        int          m;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        int          m;
        logic [31:0] d;
    } rd_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0][31:0]    m_address = '0;
    logic [N-1:0]          m_read = '0;
    logic [N-1:0]          m_write = '0;
    logic [N-1:0][31:0]    m_writedata = '0;
    logic [N-1:0]          m_waitrequest;
    logic [31:0]           m_readdata;
    logic [N-1:0]          m_readdatavalid;
    logic                  msg_enter = 1'b0;

    int checks = 0;
    int errors = 0;
    int rdv_cnt[N];
    bit rd_busy = 0;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    avalon_mm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    reg_bus_arbiter #(
        .N_MASTERS    (N),
        .ADDR_W       (32),
        .DATA_W       (32),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .reg_mm          (bus)
    );

    always #5 clk = ~clk;

    // Slave model: register file, counter at address 0, RL-deep read pipe.
    logic [31:0] mem [16];
    logic [31:0] cnt = 32'd0;
    logic [31:0] pipe [RL];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        for (int i = 0; i < RL; i++) pipe[i] = 32'hBAD0BAD0;
        for (int i = 0; i < N; i++) rdv_cnt[i] = 0;
    end

    always @(posedge clk) begin
        if (bus.write && bus.address != 32'd0) mem[bus.address[3:0]] <= bus.writedata;
        if (msg_enter) cnt <= cnt + 32'd1;
        pipe[0] <= bus.read ? ((bus.address == 32'd0) ? cnt : mem[bus.address[3:0]])
                            : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.readdata = pipe[RL-1];

    // Monitor: every slave strobe and every read return pops a scoreboard entry.
    always @(negedge clk) begin
        cmd_t        c;
        rd_t         r;
        logic [N-1:0] ew;
        if (!rst_n) begin
            rd_busy = 0;
        end else begin
            if (bus.read) begin
                checks++;
                if (rd_busy) begin
                    errors++;
                    $display("FAIL rd_overlap: read strobe while a read is outstanding");
                end
                rd_busy = 1;
            end
            if (bus.read || bus.write) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: rd=%b wr=%b addr=%h, required no strobe",
                             bus.read, bus.write, bus.address);
                end else begin
                    c  = cmd_q.pop_front();
                    ew = ~(N'(1) << c.m);
                    if (bus.write !== c.wr || bus.read !== !c.wr ||
                        bus.address !== c.a ||
                        (c.wr && bus.writedata !== c.d) ||
                        m_waitrequest !== ew) begin
                        errors++;
                        $display("FAIL cmd: wr=%b rd=%b a=%h d=%h wait=%b, required wr=%b a=%h d=%h wait=%b",
                                 bus.write, bus.read, bus.address, bus.writedata,
                                 m_waitrequest, c.wr, c.a, c.d, ew);
                    end
                end
            end
            if (m_readdatavalid != '0) begin
                rd_busy = 0;
                for (int i = 0; i < N; i++) if (m_readdatavalid[i]) rdv_cnt[i]++;
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdv_unexpected: rdv=%b data=%h, required no return",
                             m_readdatavalid, m_readdata);
                end else begin
                    r = rd_q.pop_front();
                    if (m_readdatavalid !== (N'(1) << r.m) || m_readdata !== r.d) begin
                        errors++;
                        $display("FAIL rdv: rdv=%b data=%h, required rdv=%b data=%h",
                                 m_readdatavalid, m_readdata, N'(1) << r.m, r.d);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input bit wr, input int m, input logic [31:0] a,
                            input logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.m = m; c.a = a; c.d = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_rd(input int m, input logic [31:0] d);
        rd_t r;
        r.m = m; r.d = d;
        rd_q.push_back(r);
    endtask

    // kind: 0 read, 1 write, 2 read and write together.
    task automatic master_cmd(input int m, input int kind, input logic [31:0] a,
                              input logic [31:0] d);
        bit done = 0;
        m_address[m]   = a;
        m_writedata[m] = d;
        m_read[m]      = (kind != 1);
        m_write[m]     = (kind != 0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (m_waitrequest[m] === 1'b0) done = 1;
        end
        @(posedge clk);
        #1;
        m_read[m]  = 1'b0;
        m_write[m] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_m%0d: waitrequest=%b, required a low pulse", m, m_waitrequest);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (cmd_q.size() != 0 || rd_q.size() != 0); i++) step(1);
        step(2);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        @(negedge clk);
        checks++;
        if (m_waitrequest !== '1 || m_readdatavalid !== '0 || m_readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_m: wait=%b rdv=%b rdata=%h, required 11 00 0",
                     m_waitrequest, m_readdatavalid, m_readdata);
        end
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 ||
            bus.address !== 32'd0 || bus.writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: rd=%b wr=%b a=%h d=%h, required all 0",
                     bus.read, bus.write, bus.address, bus.writedata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single_write();
        push_cmd(1, 0, 32'h2, 32'hDEADBEEF);
        master_cmd(0, 1, 32'h2, 32'hDEADBEEF);
        push_cmd(0, 0, 32'h2, 32'h0);
        push_rd(0, 32'hDEADBEEF);
        master_cmd(0, 0, 32'h2, 32'h0);
        drain();
    endtask

    task automatic test_read_write_both();
        push_cmd(1, 1, 32'h3, 32'hC0FFEE01);
        master_cmd(1, 2, 32'h3, 32'hC0FFEE01);
        push_cmd(0, 1, 32'h3, 32'h0);
        push_rd(1, 32'hC0FFEE01);
        master_cmd(1, 0, 32'h3, 32'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // m0 wins, re-requests at once, and m1 (still waiting) goes next.
        push_cmd(1, 0, 32'h4, 32'h11110000);
        push_cmd(1, 1, 32'h5, 32'h22220001);
        push_cmd(1, 0, 32'h6, 32'h33330002);
        fork
            begin
                master_cmd(0, 1, 32'h4, 32'h11110000);
                master_cmd(0, 1, 32'h6, 32'h33330002);
            end
            master_cmd(1, 1, 32'h5, 32'h22220001);
        join
        drain();
        // Pointer now sits at m1, so a fresh tie goes to m1 first.
        push_cmd(1, 1, 32'h7, 32'h44440003);
        push_cmd(1, 0, 32'h8, 32'h55550004);
        fork
            master_cmd(0, 1, 32'h8, 32'h55550004);
            master_cmd(1, 1, 32'h7, 32'h44440003);
        join
        drain();
    endtask

    task automatic test_cross_read();
        int r0;
        int r1;
        msg_enter = 1'b1;
        step(10);
        msg_enter = 1'b0;
        step(1);
        r0 = rdv_cnt[0];
        r1 = rdv_cnt[1];
        push_cmd(0, 1, 32'h0, 32'h0);
        push_rd(1, 32'd10);
        push_cmd(1, 0, 32'h9, 32'h5A5A5A5A);
        fork
            master_cmd(1, 0, 32'h0, 32'h0);
            begin
                step(1);
                master_cmd(0, 1, 32'h9, 32'h5A5A5A5A);
            end
        join
        drain();
        checks++;
        if (rdv_cnt[0] != r0 || rdv_cnt[1] != r1 + 1) begin
            errors++;
            $display("FAIL cross_rdv: m0 pulses=%0d m1 pulses=%0d, required 0 and 1",
                     rdv_cnt[0] - r0, rdv_cnt[1] - r1);
        end
    endtask

    task automatic test_latency();
        int n = 0;
        bit seen = 0;
        push_cmd(0, 0, 32'h2, 32'h0);
        push_rd(0, 32'hDEADBEEF);
        fork
            master_cmd(0, 0, 32'h2, 32'h0);
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                n++;
                if (m_readdatavalid[0] === 1'b1) seen = 1;
            end
        join
        // Cycles counted inclusively from the first IDLE cycle with the request.
        checks++;
        if (!seen || n != RL + 3) begin
            errors++;
            $display("FAIL latency: %0d cycles (seen=%0d), required %0d", n, seen, RL + 3);
        end
        drain();
        // Pointer is at m1: m1 first, then m0 twice; reads never overlap.
        push_cmd(0, 1, 32'h5, 32'h0);
        push_cmd(0, 0, 32'h4, 32'h0);
        push_cmd(0, 0, 32'h4, 32'h0);
        push_rd(1, 32'h22220001);
        push_rd(0, 32'h11110000);
        push_rd(0, 32'h11110000);
        fork
            begin
                master_cmd(0, 0, 32'h4, 32'h0);
                master_cmd(0, 0, 32'h4, 32'h0);
            end
            master_cmd(1, 0, 32'h5, 32'h0);
        join
        drain();
    endtask

    task automatic test_reset_mid_read();
        push_cmd(0, 0, 32'h2, 32'h0);
        master_cmd(0, 0, 32'h2, 32'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m_readdatavalid !== '0 || m_waitrequest !== '1 || bus.read !== 1'b0) begin
                errors++;
                $display("FAIL midrst_%0d: rdv=%b wait=%b rd=%b, required 00 11 0",
                         i, m_readdatavalid, m_waitrequest, bus.read);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        push_cmd(1, 0, 32'hA, 32'h66660005);
        push_cmd(1, 1, 32'hB, 32'h77770006);
        fork
            master_cmd(0, 1, 32'hA, 32'h66660005);
            master_cmd(1, 1, 32'hB, 32'h77770006);
        join
        step(RL + 6);
        drain();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (bus.read !== 1'b0 || bus.write !== 1'b0 || m_waitrequest !== '1) begin
                errors++;
                $display("FAIL idle_%0d: rd=%b wr=%b wait=%b, required 0 0 11",
                         i, bus.read, bus.write, m_waitrequest);
            end
        end
        step(1);
    endtask

    initial begin
        step(1);
        test_reset();
        test_single_write();
        test_read_write_both();
        test_back_to_back();
        test_cross_read();
        test_latency();
        test_reset_mid_read();
        test_idle();
        checks++;
        if (cmd_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d cmds %0d reads left, required 0 0",
                     cmd_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares one Avalon-MM register slave between N_MASTERS requesters, for example a host CPU bridge and a debug/loopback test master.
- Sits between the masters and the `reg_mm` port of `registers_controller`.
- Grants one transaction at a time, using round-robin priority.
- Returns read data only to the master that issued the read.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width on both sides.
- READ_LATENCY, 1, fixed slave read latency in cycles, measured from the read-issue edge to the edge at which `reg_mm.readdata` is valid (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- m_address  in  N_MASTERS x ADDR_W  per-master address
- m_read  in  N_MASTERS  per-master read request
- m_write  in  N_MASTERS  per-master write request
- m_writedata  in  N_MASTERS x DATA_W  per-master write data
- m_waitrequest  out  N_MASTERS  per-master stall; low for exactly one cycle when that master's command is accepted
- m_readdata  out  DATA_W  shared read-data bus
- m_readdatavalid  out  N_MASTERS  one-cycle read return strobe, driven only to the owning master
- reg_mm  master side  avalon_mm_if  slave bus (address, read, write, writedata, readdata)

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr_ptr=0, all m_waitrequest=1, m_readdatavalid=0, m_readdata=0.
  - reg_mm.read=0, reg_mm.write=0, reg_mm.address=0, reg_mm.writedata=0.
- Masters hold read/write, address and writedata stable while their m_waitrequest=1 (Avalon rule).
  - read and write asserted together by one master is treated as a write.
- FSM states: IDLE, ISSUE, RD_WAIT, RD_RET.
- IDLE:
  - If any request is pending, the winner is the first requesting index at or after rr_ptr, searched cyclically.
  - Latch the winner's grant index, command, address and writedata into the slave-side registers.
  - Next state: ISSUE.
  - With no request, remain in IDLE with all slave strobes at 0.
- ISSUE (exactly 1 cycle):
  - reg_mm drives the latched command.
  - m_waitrequest[grant]=0 in this cycle only; all other m_waitrequest bits stay 1.
  - rr_ptr <= (grant+1) mod N_MASTERS.
  - Write: next state IDLE.
  - Read: load lat_cnt=READ_LATENCY-1; next state RD_WAIT if lat_cnt>0, else RD_RET.
- RD_WAIT: decrement lat_cnt each cycle; at 0, go to RD_RET.
- RD_RET:
  - Capture reg_mm.readdata into m_readdata.
  - Next cycle: pulse m_readdatavalid[grant]=1 for one cycle and return to IDLE.
  - m_readdata holds its value until the next read return.
- Throughput: a write occupies 2 cycles; a read occupies READ_LATENCY+3 cycles (request to readdatavalid).
- Requests arriving during a busy period wait with m_waitrequest=1. Arbitration happens only in IDLE.
- A request withdrawn after latching is still completed on the slave (protocol violation; no abort).
- rst_n low mid-read: the transaction is abandoned, no readdatavalid is emitted, and rr_ptr returns to 0.
- No combinational path from m_* inputs to reg_mm outputs. m_waitrequest is decoded from state and the registered grant only.

Decomposition:
- Package reg_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RD_WAIT, RD_RET);
  - the GRANT_W = $clog2(N_MASTERS) helper;
  - a function next_rr(ptr, req) returning the winning index.
- One sub-module is natural: rr_arbiter, a combinational round-robin grant computation from req and rr_ptr. The FSM and datapath stay in reg_bus_arbiter.

Test Plan:
- Single write: master0 writes 0xDEADBEEF to addr 0x2 → reg_mm.write high for exactly 1 cycle with those values; m_waitrequest[0] low in that cycle; readback from addr 0x2 returns 0xDEADBEEF with m_readdatavalid[0] only.
- Contention: both masters request in the same cycle after reset → master0 is served first, then master1. Repeating the test with both requesting again gives master1 then master0 (rotation).
- Cross-read: master1 reads addr 0x0 (counter) while master0 is blocked → m_readdatavalid[1] pulses once and m_readdatavalid[0] never pulses. Data equals the counter value at issue, e.g. 10 after 10 msg_enter cycles.
- Latency: READ_LATENCY=3 build → readdatavalid arrives 6 cycles after the request is first seen in IDLE; back-to-back reads are never overlapped on reg_mm.
- Reset mid-read: assert rst_n=0 during RD_WAIT → no readdatavalid; all waitrequest=1; after release the first request is granted to master0.
- Idle bus: no requests for 100 cycles → reg_mm.read and reg_mm.write stay 0, and all m_waitrequest stay 1.
